// File: rtl/spi_master_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_mc                                                |
// | Description : Parametrised SPI master. It supports run-time CPOL/CPHA and  |
// |               bit order, DATA_W-bit words, and NUM_CS one-hot active-low   |
// |               chip selects. The front end uses a start/busy/done           |
// |               handshake. A transfer runs IDLE -> SETUP -> TRANSFER ->      |
// |               HOLD -> DONE -> IDLE.                                        |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               start_i, tx_data_i, cs_sel_i, cpol_i, cpha_i, lsb_first_i    |
// |               rx_data_o, busy_o, done_o                                    |
// |               sclk_o, mosi_o, miso_i, cs_n_o                               |
// | Option      : SPI_CS_HOLD_EN adds hold_cs_i. It keeps CS asserted between  |
// |               transfers to the same slave.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master_mc #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
`ifdef SPI_CS_HOLD_EN
    input  logic              hold_cs_i,
`endif
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [NUM_CS-1:0] cs_n_o
);

    localparam int c_DIV_W  = $clog2(CLK_DIV);
    localparam int c_BIT_W  = $clog2(DATA_W);
    localparam int c_EDGE_W = c_BIT_W + 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_W - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_DIV_W-1:0]  div_q, div_d;
    logic [c_EDGE_W-1:0] edge_q, edge_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
`ifdef SPI_CS_HOLD_EN
    logic                hold_q, hold_d;
    logic                held_q, held_d;
`endif

    logic                w_div_tc;
    logic                w_leading;
    logic [c_BIT_W-1:0]  w_bit;
    logic                w_cs_ok;
    logic                w_cs_active;

    // Word position of the k-th bit on the wire. The same mapping is used for
    // shifting out and sampling in, so rx lands bit-aligned like tx.
    function automatic logic [c_BIT_W-1:0] f_pos(input logic [c_BIT_W-1:0] k, input logic lsb);
        return lsb ? k : (c_BIT_LAST - k);
    endfunction

    assign w_div_tc  = (div_q == c_DIV_LAST);
    assign w_leading = ~edge_q[0];              // even-numbered edges are leading
    assign w_bit     = edge_q[c_EDGE_W-1:1];    // bit slot this edge belongs to
    assign w_cs_ok   = (int'(cs_sel_i) < NUM_CS);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
`ifdef SPI_CS_HOLD_EN
        hold_d    = hold_q;
        held_d    = held_q;
`endif
        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                edge_d = '0;
`ifdef SPI_CS_HOLD_EN
                sclk_d = held_q ? cpol_q : cpol_i;
`else
                sclk_d = cpol_i;
`endif
                if (start_i && w_cs_ok) begin
                    tx_d    = tx_data_i;
                    cs_d    = cs_sel_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_first_i;
                    sclk_d  = cpol_i;
                    rx_sh_d = '0;
                    mosi_d  = tx_data_i[f_pos('0, lsb_first_i)];
                    state_d = S_SETUP;
`ifdef SPI_CS_HOLD_EN
                    hold_d  = hold_cs_i;
                    // CS already low on this slave: no setup time needed
                    if (held_q && (cs_sel_i == cs_q)) begin
                        state_d = S_XFER;
                    end
`endif
                end
            end
            S_SETUP: begin
                div_d = div_q + 1'b1;
                if (w_div_tc) begin
                    div_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                div_d = div_q + 1'b1;
                if (w_div_tc) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (w_leading ^ cpha_q) begin
                        // CPHA=0 samples on leading, CPHA=1 on trailing
                        rx_sh_d[f_pos(w_bit, lsb_q)] = miso_i;
                    end else if (cpha_q) begin
                        // CPHA=1 leading edge presents this slot's bit
                        mosi_d = tx_q[f_pos(w_bit, lsb_q)];
                    end else if (edge_q != c_EDGE_LAST) begin
                        // CPHA=0 trailing edge advances to the next slot
                        mosi_d = tx_q[f_pos(w_bit + 1'b1, lsb_q)];
                    end
                    if (edge_q == c_EDGE_LAST) begin
                        edge_d  = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                div_d = div_q + 1'b1;
                if (w_div_tc) begin
                    div_d     = '0;
                    rx_data_d = rx_sh_q;
                    state_d   = S_DONE;
`ifdef SPI_CS_HOLD_EN
                    held_d    = hold_q;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cs_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
`ifdef SPI_CS_HOLD_EN
            hold_q    <= 1'b0;
            held_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
`ifdef SPI_CS_HOLD_EN
            hold_q    <= hold_d;
            held_q    <= held_d;
`endif
        end
    end

    assign busy_o    = (state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_HOLD);
    assign done_o    = (state_q == S_DONE);
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign rx_data_o = rx_data_q;

`ifdef SPI_CS_HOLD_EN
    assign w_cs_active = busy_o | held_q;
`else
    assign w_cs_active = busy_o;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_n_o[gi] = ~(w_cs_active && (cs_q == CS_W'(gi)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_mc                                             |
// | Description : Self-checking bench for spi_master_mc. It uses a default     |
// |               8-bit/4-CS instance and a 16-bit, CLK_DIV=2, 5-CS instance.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master_mc;

    localparam int c_DW    = 8;
    localparam int c_CD    = 4;
    localparam int c_LAT   = 1 + (2 * c_DW + 2) * c_CD;      // done cycle after start edge
    localparam int c_DW_B  = 16;
    localparam int c_CD_B  = 2;
    localparam int c_LAT_B = 1 + (2 * c_DW_B + 2) * c_CD_B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [1:0] cs_sel = '0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [7:0] rx_data;
    logic       busy, done, sclk, mosi, miso;
    logic [3:0] cs_n;

    // Slave model: either loops mosi back or serves slave_word in wire order
    bit         loopback = 1'b1;
    logic [7:0] slave_word = '0;
    int         slave_idx = 0;

    logic        b_start = 1'b0;
    logic [15:0] b_tx = '0;
    logic [2:0]  b_sel = '0;
    logic [15:0] b_rx;
    logic        b_busy, b_done, b_sclk, b_mosi;
    logic [4:0]  b_cs_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int f_pos(input int k, input bit lsb);
        return lsb ? k : (7 - k);
    endfunction

    always_comb begin
        miso = 1'b0;
        if (loopback) miso = mosi;
        else if (slave_idx < 8) miso = slave_word[f_pos(slave_idx, lsb_first)];
    end

    spi_master_mc #(.DATA_W(c_DW), .CLK_DIV(c_CD), .NUM_CS(4)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .tx_data_i(tx_data), .cs_sel_i(cs_sel),
        .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb_first),
`ifdef SPI_CS_HOLD_EN
        .hold_cs_i(1'b0),
`endif
        .rx_data_o(rx_data), .busy_o(busy), .done_o(done), .sclk_o(sclk),
        .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
    );

    spi_master_mc #(.DATA_W(c_DW_B), .CLK_DIV(c_CD_B), .NUM_CS(5)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .tx_data_i(b_tx), .cs_sel_i(b_sel),
        .cpol_i(1'b0), .cpha_i(1'b1), .lsb_first_i(1'b1),
`ifdef SPI_CS_HOLD_EN
        .hold_cs_i(1'b0),
`endif
        .rx_data_o(b_rx), .busy_o(b_busy), .done_o(b_done), .sclk_o(b_sclk),
        .mosi_o(b_mosi), .miso_i(b_mosi), .cs_n_o(b_cs_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer on the 8-bit instance. spam keeps start high with a different
    // word/select through busy and DONE. rst_edge >= 0 aborts with rst after
    // that many sclk edges.
    task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [1:0] sel,
                            input bit pol, input bit pha, input bit lsb, input bit loop,
                            input logic [7:0] mword, input logic [7:0] exp_rx,
                            input logic [3:0] exp_cs, input bit spam, input int rst_edge);
        int cyc, nedge, cs_bad, dones, busy_bad;
        logic prev;
        logic [7:0] obs;
        bit aborted;
        cpol = pol;
        @(posedge clk); #1;
        chk({tag, "_idle_sclk"}, sclk, pol);
        tx_data = tx; cs_sel = sel; cpha = pha; lsb_first = lsb;
        loopback = loop; slave_word = mword; slave_idx = 0; start = 1'b1;
        @(posedge clk); #1;
        if (spam) begin
            tx_data = 8'hFF;
            cs_sel = sel + 2'd1;
        end else begin
            start = 1'b0;
        end
        cyc = 1; nedge = 0; cs_bad = 0; prev = pol; obs = '0; aborted = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        while (!done && cyc < 400) begin
            if (cs_n !== exp_cs) cs_bad++;
            if (sclk !== prev) begin
                // leading edges are the even ones; CPHA picks which one samples
                if (((nedge % 2) == 0) == (pha == 1'b0)) begin
                    obs[f_pos(nedge / 2, lsb)] = mosi;
                    slave_idx = nedge / 2 + 1;
                end
                nedge++;
                prev = sclk;
            end
            if (rst_edge >= 0 && nedge == rst_edge) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk({tag, "_cs_n"}, cs_n, 4'hF);
            chk({tag, "_sclk"}, sclk, 0);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_rx"}, rx_data, 0);
            dones = 0;
            busy_bad = 0;
            for (int i = 0; i < 120; i++) begin
                if (done) dones++;
                if (busy) busy_bad++;
                @(posedge clk); #1;
            end
            chk({tag, "_no_done"}, dones, 0);
            chk({tag, "_no_busy"}, busy_bad, 0);
        end else begin
            chk({tag, "_done_cycle"}, cyc, c_LAT);
            chk({tag, "_rx"}, rx_data, exp_rx);
            chk({tag, "_edges"}, nedge, 2 * c_DW);
            chk({tag, "_mosi"}, obs, tx);
            chk({tag, "_cs_busy"}, cs_bad, 0);
            chk({tag, "_cs_done"}, cs_n, 4'hF);
            chk({tag, "_busy_done"}, busy, 0);
            chk({tag, "_sclk_done"}, sclk, pol);
            dones = 1;
            busy_bad = 0;
            @(posedge clk); #1;
            start = 1'b0;
            tx_data = tx;
            cs_sel = sel;
            for (int i = 0; i < 6; i++) begin
                if (done) dones++;
                if (busy) busy_bad++;
                @(posedge clk); #1;
            end
            chk({tag, "_one_done"}, dones, 1);
            chk({tag, "_idle_after"}, busy_bad, 0);
            chk({tag, "_rx_held"}, rx_data, exp_rx);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] sel;
        bit         pol;
        bit         pha;
        bit         lsb;
        bit         loop;
        logic [7:0] mword;
        logic [7:0] exp_rx;
        logic [3:0] exp_cs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_cyc, b_bad;
        logic [7:0] r_tx, r_mw;
        logic [1:0] r_sel;
        bit r_pol, r_pha, r_lsb, r_loop;

        vecs[0] = '{8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 4'b1011};
        vecs[1] = '{8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 8'h81, 4'b1110};
        vecs[2] = '{8'h96, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3E, 8'h3E, 4'b1101};
        vecs[3] = '{8'h0F, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h0F, 4'b0111};
        vecs[4] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 4'b1110};
        vecs[5] = '{8'hFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0111};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_b_cs_n", b_cs_n, 5'h1F);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].sel, vecs[i].pol,
                     vecs[i].pha, vecs[i].lsb, vecs[i].loop, vecs[i].mword,
                     vecs[i].exp_rx, vecs[i].exp_cs, 1'b0, -1);
        end

        run_xfer("spam", 8'h6B, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h6B, 4'b1101, 1'b1, -1);
        run_xfer("abort", 8'hC3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b1011, 1'b0, 7);
        run_xfer("after_rst", 8'h5A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 4'b1011, 1'b0, -1);

        // Randomised transfers. The slave either echoes mosi or serves its own word.
        for (int i = 0; i < 8; i++) begin
            r_tx   = 8'($urandom);
            r_mw   = 8'($urandom);
            r_sel  = 2'($urandom_range(0, 3));
            r_pol  = 1'($urandom);
            r_pha  = 1'($urandom);
            r_lsb  = 1'($urandom);
            r_loop = 1'($urandom);
            run_xfer($sformatf("rnd%0d", i), r_tx, r_sel, r_pol, r_pha, r_lsb, r_loop, r_mw,
                     r_loop ? r_tx : r_mw, ~(4'b0001 << r_sel), 1'b0, -1);
        end

        // 16-bit instance, loopback
        b_tx = 16'hBEEF; b_sel = 3'd4; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_cyc = 1;
        chk("b_cs_n", b_cs_n, 5'b01111);
        while (!b_done && b_cyc < 400) begin
            @(posedge clk); #1;
            b_cyc++;
        end
        chk("b_done_cycle", b_cyc, c_LAT_B);
        chk("b_rx", b_rx, 16'hBEEF);
        @(posedge clk); #1;

        // Out-of-range selects are ignored even with start held high
        for (int s = 5; s < 8; s += 2) begin
            b_sel = 3'(s); b_start = 1'b1; b_bad = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (b_busy || b_done || (b_cs_n !== 5'h1F)) b_bad++;
            end
            b_start = 1'b0;
            chk($sformatf("b_badsel%0d", s), b_bad, 0);
        end
        chk("b_rx_kept", b_rx, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
